// File: rtl/dram_mp.sv
// dram_mp -- multi-read-port distributed RAM with per-byte writes and a
// self-timed clear sweep.
//
// Parameters:
//   RAM_WIDTH      data width in bits (multiple of 8)
//   RAM_DEPTH      number of words (<= 2**RAM_ADDR_WIDTH)
//   RAM_ADDR_WIDTH address width
//   NUM_RD         number of independent read ports (1..4)
//   RD_LATENCY     0: asynchronous read, 1: registered read
//   BYPASS         1: write-first forwarding, 0: read-old (RD_LATENCY=1 only)
//
// Ports:
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset
//   clr     one-cycle request to zero the whole array
//   busy    clear sweep in progress
//   wen     per-byte write enables
//   waddr   write address
//   din     write data
//   ren     per-port read enables
//   raddr   packed read addresses, port i at [i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]
//   dout    packed read data, port i at [i*RAM_WIDTH +: RAM_WIDTH]
//   rvalid  per-port read data valid
module dram_mp #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = 4096,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int NUM_RD         = 2,
    parameter int RD_LATENCY     = 1,
    parameter int BYPASS         = 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             clr,
    output logic                             busy,
    input  logic [RAM_WIDTH/8-1:0]           wen,
    input  logic [RAM_ADDR_WIDTH-1:0]        waddr,
    input  logic [RAM_WIDTH-1:0]             din,
    input  logic [NUM_RD-1:0]                ren,
    input  logic [NUM_RD*RAM_ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*RAM_WIDTH-1:0]      dout,
    output logic [NUM_RD-1:0]                rvalid
);

    localparam int NB = RAM_WIDTH / 8;
    localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    // One extra bit so RAM_DEPTH == 2**RAM_ADDR_WIDTH is representable.
    localparam logic [RAM_ADDR_WIDTH:0] DEPTH_L = RAM_DEPTH[RAM_ADDR_WIDTH:0];
    localparam logic [IW-1:0]           LAST_L  = IW'(RAM_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_clr_addr;
    logic             w_waddr_ok;
    logic             w_wr_act;

    (* ram_style = "distributed" *) logic [RAM_WIDTH-1:0] r_ram [RAM_DEPTH];

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
            else                  r_clr_addr <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (clr) w_next = CLEAR;
            CLEAR:   if (r_clr_addr == LAST_L) w_next = IDLE;
            default: w_next = CLEAR;
        endcase
    end

    always_comb begin
        busy = (r_state == CLEAR);
    end

    // ---------------- write path ----------------
    assign w_waddr_ok = ({1'b0, waddr} < DEPTH_L);
    // A clr request on an idle edge wins over a simultaneous user write.
    assign w_wr_act   = (r_state == IDLE) && !clr && w_waddr_ok;

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_ram[r_clr_addr] <= '0;
        end else if (w_wr_act) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wen[b]) r_ram[waddr[IW-1:0]][b*8 +: 8] <= din[b*8 +: 8];
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [RAM_ADDR_WIDTH-1:0] w_addr;
        logic                      w_ok;
        logic [RAM_WIDTH-1:0]      w_old;

        assign w_addr = raddr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        assign w_ok   = ({1'b0, w_addr} < DEPTH_L);
        assign w_old  = w_ok ? r_ram[w_addr[IW-1:0]] : '0;

        if (RD_LATENCY == 0) begin : g_async
            assign dout[i*RAM_WIDTH +: RAM_WIDTH] = w_old;
            assign rvalid[i]                      = ren[i] & ~busy;
        end else begin : g_sync
            logic [RAM_WIDTH-1:0] w_fwd;
            logic [RAM_WIDTH-1:0] r_dout;
            logic                 r_valid;

            // Merge bytes being written this edge so the read sees write-first data.
            always_comb begin
                w_fwd = w_old;
                if (BYPASS != 0 && w_wr_act && waddr == w_addr) begin
                    for (int unsigned b = 0; b < NB; b++) begin
                        if (wen[b]) w_fwd[b*8 +: 8] = din[b*8 +: 8];
                    end
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else if (ren[i] && !busy) begin
                    r_dout  <= w_fwd;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            assign dout[i*RAM_WIDTH +: RAM_WIDTH] = r_dout;
            assign rvalid[i]                      = r_valid;
        end
    end

endmodule

// File: tb/tb_dram_mp.sv
module tb_dram_mp;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 5;

    logic            clk    = 1'b0;
    logic            resetn = 1'b1;
    logic            clr    = 1'b0;
    logic [3:0]      wen    = '0;
    logic [AW-1:0]   waddr  = '0;
    logic [W-1:0]    din    = '0;
    logic [1:0]      ren    = '0;
    logic [2*AW-1:0] raddr  = '0;

    logic            busy, busy_ro;
    logic [2*W-1:0]  dout, dout_ro;
    logic [1:0]      rvalid, rvalid_ro;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dram_mp #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_ADDR_WIDTH(AW), .NUM_RD(2),
              .RD_LATENCY(1), .BYPASS(1)) dut (
        .clk(clk), .resetn(resetn), .clr(clr), .busy(busy),
        .wen(wen), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout), .rvalid(rvalid)
    );

    dram_mp #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_ADDR_WIDTH(AW), .NUM_RD(2),
              .RD_LATENCY(1), .BYPASS(0)) dut_ro (
        .clk(clk), .resetn(resetn), .clr(clr), .busy(busy_ro),
        .wen(wen), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout_ro), .rvalid(rvalid_ro)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] w);
        waddr = a; din = d; wen = w;
        tick();
        wen = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0}; ren = 2'b11;
        tick();
        ren = '0;
    endtask

    task automatic test_reset();
        int n;
        #2 resetn = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passes++;
        checks++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", rvalid); else passes++;
        checks++; if (dout !== 64'h0) $display("FAIL reset_dout: got %h expected 0", dout); else passes++;
        resetn = 1'b1;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) $display("FAIL reset_sweep_len: got %0d expected 16", n); else passes++;
        for (int i = 0; i < D; i++) begin
            do_read(AW'(i), AW'(D - 1 - i));
            checks++; if (dout !== 64'h0 || rvalid !== 2'b11)
                $display("FAIL post_reset_read[%0d]: got %h/%b expected 0/11", i, dout, rvalid); else passes++;
        end
    endtask

    task automatic test_byte_write();
        do_write(5'd3, 32'hDEADBEEF, 4'b1111);
        do_write(5'd3, 32'h11223344, 4'b0001);
        raddr = {5'd3, 5'd3}; ren = 2'b11;
        checks++; if (rvalid !== 2'b00) $display("FAIL bw_rvalid_early: got %b expected 00", rvalid); else passes++;
        tick();
        ren = '0;
        checks++; if (dout !== {32'hDEADBE44, 32'hDEADBE44})
            $display("FAIL bw_dout: got %h expected deadbe44deadbe44", dout); else passes++;
        checks++; if (rvalid !== 2'b11) $display("FAIL bw_rvalid: got %b expected 11", rvalid); else passes++;
        tick();
        checks++; if (rvalid !== 2'b00) $display("FAIL bw_rvalid_drop: got %b expected 00", rvalid); else passes++;
        checks++; if (dout !== {32'hDEADBE44, 32'hDEADBE44})
            $display("FAIL bw_dout_hold: got %h expected deadbe44deadbe44", dout); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e0, e1;
        for (int k = 1; k <= 4; k++) do_write(AW'(k + 8), 32'h1000_0000 + W'(k), 4'b1111);
        ren = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            raddr = {AW'(13 - k), AW'(k + 8)};
            tick();
            e0 = 32'h1000_0000 + W'(k);
            e1 = 32'h1000_0000 + W'(5 - k);
            checks++; if (dout !== {e1, e0} || rvalid !== 2'b11)
                $display("FAIL b2b[%0d]: got %h/%b expected %h/11", k, dout, rvalid, {e1, e0}); else passes++;
        end
        ren = '0;
    endtask

    task automatic test_bypass();
        do_write(5'd5, 32'h12345678, 4'b1111);
        waddr = 5'd5; din = 32'hA5A5A5A5; wen = 4'b1100;
        raddr = {5'd5, 5'd5}; ren = 2'b11;
        tick();
        wen = '0; ren = '0;
        checks++; if (dout !== {32'hA5A55678, 32'hA5A55678})
            $display("FAIL bypass_fwd: got %h expected a5a55678a5a55678", dout); else passes++;
        checks++; if (dout_ro !== {32'h12345678, 32'h12345678} || rvalid_ro !== 2'b11)
            $display("FAIL bypass_old: got %h/%b expected 1234567812345678/11", dout_ro, rvalid_ro); else passes++;
        do_read(5'd5, 5'd5);
        checks++; if (dout_ro !== {32'hA5A55678, 32'hA5A55678})
            $display("FAIL bypass_old_after: got %h expected a5a55678a5a55678", dout_ro); else passes++;
    endtask

    task automatic test_clear();
        int n;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL clr_busy_start: got %b expected 1", busy); else passes++;
        n = 0;
        while (busy && n < 100) begin
            if (n == 3) begin
                waddr = 5'd2; din = 32'hFFFFFFFF; wen = 4'b1111;
                raddr = {5'd2, 5'd2}; ren = 2'b11;
            end
            if (n == 7) clr = 1'b1;
            tick();
            n++;
            wen = '0; ren = '0; clr = 1'b0;
            if (n == 4) begin
                checks++; if (rvalid !== 2'b00) $display("FAIL clr_no_rvalid: got %b expected 00", rvalid); else passes++;
            end
        end
        checks++; if (n !== 16) $display("FAIL clr_sweep_len: got %0d expected 16", n); else passes++;
        for (int i = 0; i < D; i++) begin
            do_read(AW'(i), AW'(i));
            checks++; if (dout !== 64'h0 || rvalid !== 2'b11)
                $display("FAIL clr_read[%0d]: got %h/%b expected 0/11", i, dout, rvalid); else passes++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        do_write(5'd9, 32'h99999999, 4'b1111);
        do_read(5'd9, 5'd9);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", busy); else passes++;
        checks++; if (dout !== 64'h0) $display("FAIL midrst_dout: got %h expected 0", dout); else passes++;
        checks++; if (rvalid !== 2'b00) $display("FAIL midrst_rvalid: got %b expected 00", rvalid); else passes++;
        tick(); tick();
        resetn = 1'b1;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) $display("FAIL midrst_sweep_len: got %0d expected 16", n); else passes++;
        do_read(5'd9, 5'd0);
        checks++; if (dout !== 64'h0) $display("FAIL midrst_read: got %h expected 0", dout); else passes++;
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] e;
        do_write(5'd15, 32'h0F0F0F0F, 4'b1111);
        do_write(5'd0, 32'h00C0FFEE, 4'b1111);
        do_read(5'd15, 5'd15);
        checks++; if (dout !== {32'h0F0F0F0F, 32'h0F0F0F0F})
            $display("FAIL oor_preload: got %h expected 0f0f0f0f0f0f0f0f", dout); else passes++;
        do_write(5'h1F, 32'hFFFFFFFF, 4'b1111);
        do_write(5'h10, 32'hFFFFFFFF, 4'b1111);
        do_read(5'd15, 5'h1F);
        checks++; if (dout[63:32] !== 32'h0) $display("FAIL oor_read_dout1: got %h expected 0", dout[63:32]); else passes++;
        checks++; if (rvalid !== 2'b11) $display("FAIL oor_read_rvalid: got %b expected 11", rvalid); else passes++;
        for (int i = 0; i < D; i++) begin
            do_read(AW'(i), AW'(i));
            e = (i == 15) ? 32'h0F0F0F0F : ((i == 0) ? 32'h00C0FFEE : 32'h0);
            checks++; if (dout[31:0] !== e)
                $display("FAIL oor_words[%0d]: got %h expected %h", i, dout[31:0], e); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_bypass();
        test_clear();
        test_reset_mid_sweep();
        test_out_of_range();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule
